// File: rtl/fifo_ctrl.sv
// Pointer and flag controller that turns reg_file_dyn into a first-word-fall-through FIFO.
// Optional occupancy output o_fill_count is enabled by defining FIFO_CTRL_COUNT_EN.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic                  i_rd,
    output logic                  o_rf_write_en,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [ADDR_WIDTH-1:0] o_read_addr,
`ifdef FIFO_CTRL_COUNT_EN
    output logic [ADDR_WIDTH:0]   o_fill_count,
`endif
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_inc_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_inc_s;
`ifdef FIFO_CTRL_COUNT_EN
    logic [ADDR_WIDTH:0]   count_q, count_d;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
`endif

    // Accept/reject decisions and next-state for pointers, flags and pulses
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        full_d       = full_q;
        empty_d      = empty_q;
        wr_ptr_inc_s = wr_ptr_q + PTR_ONE;
        rd_ptr_inc_s = rd_ptr_q + PTR_ONE;
        // A push while full is only legal when the head is popped in the same cycle
        push_ok_s    = i_wr & (~full_q | i_rd);
        pop_ok_s     = i_rd & ~empty_q;
        overflow_d   = i_wr & ~push_ok_s;
        underflow_d  = i_rd & empty_q & ~i_wr;

        case ({push_ok_s, pop_ok_s})
            2'b10: begin
                wr_ptr_d = wr_ptr_inc_s;
                empty_d  = 1'b0;
                full_d   = (wr_ptr_inc_s == rd_ptr_q);
            end
            2'b01: begin
                rd_ptr_d = rd_ptr_inc_s;
                full_d   = 1'b0;
                empty_d  = (rd_ptr_inc_s == wr_ptr_q);
            end
            2'b11: begin
                wr_ptr_d = wr_ptr_inc_s;
                rd_ptr_d = rd_ptr_inc_s;
            end
            default: begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
            end
        endcase
    end

`ifdef FIFO_CTRL_COUNT_EN
    // Occupancy moves only when exactly one side of the transfer is accepted
    always_comb begin
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Occupancy register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign o_fill_count = count_q;
`endif

    // Pointer, flag and error-pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_rf_write_en = push_ok_s & ~i_rst;
    assign o_write_addr  = wr_ptr_q;
    assign o_read_addr   = rd_ptr_q;
    assign o_full        = full_q;
    assign o_empty       = empty_q;
    assign o_overflow    = overflow_q;
    assign o_underflow   = underflow_q;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Address and flag controller that sits in front of reg_file_dyn and turns it into a first-word-fall-through FIFO.
- Converts push/pop requests into the register file's write-enable, write-address and read-address.
- Maintains write/read pointers, full/empty flags and error pulses.
- Head-of-queue data appears combinationally from the register file at the address driven on o_read_addr.

Parameters:
ADDR_WIDTH, 2, pointer width; FIFO depth = 2**ADDR_WIDTH entries (must match the attached register file)

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_wr  input  1  push request; data presented to register file i_write_data in the same cycle
i_rd  input  1  pop request; consumes entry currently at o_read_addr
o_rf_write_en  output  1  write enable to register file (accepted push)
o_write_addr  output  ADDR_WIDTH  register file write address (= write pointer)
o_read_addr  output  ADDR_WIDTH  register file read address (= read pointer, head of queue)
o_full  output  1  FIFO holds 2**ADDR_WIDTH entries
o_empty  output  1  FIFO holds 0 entries
o_overflow  output  1  one-cycle pulse: push rejected because full
o_underflow  output  1  one-cycle pulse: pop rejected because empty

Behaviour:
- Reset (i_rst=1 at clock edge), regardless of i_wr/i_rd:
  - pointers = 0; o_empty=1; o_full=0; o_overflow=0; o_underflow=0.
  - o_rf_write_en is combinational but gated to 0 while i_rst=1.
  - A reset mid-stream discards all contents; no entry survives.
- Pointers, flags and pulses are registered. o_write_addr and o_read_addr come straight from the pointer registers.
- o_rf_write_en = i_wr & (~o_full | i_rd) & ~i_rst (combinational).
- Per-cycle action, decided on {i_wr, i_rd}:
  - 00: no change.
  - 10, not full: write pointer +1; empty<=0; full<=1 if the next write pointer equals the read pointer.
  - 10, full: no state change; overflow pulse next cycle; o_rf_write_en=0.
  - 01, not empty: read pointer +1; full<=0; empty<=1 if the next read pointer equals the write pointer.
  - 01, empty: no state change; underflow pulse next cycle.
  - 11, neither flag: both pointers +1; flags unchanged.
  - 11, empty: write only (10 rule applies); the pop is ignored and no underflow pulse is raised. FWFT data is not yet valid.
  - 11, full: both pointers +1; full stays 1. The write targets the slot being read this cycle; the register file's combinational read returns the old head, and the write lands at the clock edge.
- Pointers are modulo 2**ADDR_WIDTH and wrap naturally from max to 0. Full and empty disambiguate equal pointers.
- o_empty and o_full are never 1 simultaneously.
- Latency:
  - a pushed word is visible at o_read_addr's data the cycle after the push;
  - after a pop, the next head is visible the cycle after the pop.
- o_overflow/o_underflow are high for exactly one cycle per rejected request; they are not sticky.

Optional Feature:
FIFO_CTRL_COUNT_EN:
- Defined: adds output o_fill_count [ADDR_WIDTH:0].
  - Registered occupancy, reset 0.
  - +1 on an accepted push only; -1 on an accepted pop only; unchanged on a simultaneous accepted push+pop.
  - Ranges 0..2**ADDR_WIDTH; equals 2**ADDR_WIDTH exactly when o_full=1 and 0 exactly when o_empty=1.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
1. After reset, ADDR_WIDTH=2: push 0xA1,0xB2,0xC3,0xD4 on consecutive cycles -> o_write_addr 0,1,2,3; o_empty falls after the first push; o_full=1 after the 4th push; count=4 if enabled.
2. From full, push 0xEE -> o_rf_write_en=0, o_overflow=1 for one cycle, contents unchanged; then pop 4 times -> register file read data 0xA1,0xB2,0xC3,0xD4; o_empty=1 after the 4th pop.
3. From empty, pop -> o_underflow=1 for one cycle, o_read_addr stays 0; push and pop together on empty -> write only, o_empty=0 next cycle, no underflow.
4. Wrap-around: 6 pushes interleaved with 6 pops -> pointers wrap 3->0; data order preserved; flags correct at each step.
5. Full with simultaneous push 0x55 and pop -> old head is read, both pointers advance, o_full stays 1; four more pops return the remaining 3 entries then 0x55.
6. Assert i_rst with 3 entries stored -> next cycle o_empty=1, o_full=0, both addresses 0, count=0 if enabled.
